// File: rtl/sdram_cmd_monitor.sv
// Passive SDRAM command-bus monitor. It decodes every sampled command,
// tracks per-bank open/row state and the time since each bank's ACT, and
// counts refreshes while watching the refresh interval. It also predicts
// rd_valid from the CAS latency and latches protocol violations into sticky
// error flags. It only observes the bus and never drives it.
module sdram_cmd_monitor #(
  parameter int NUM_BANKS = 4,
  parameter int BA_W      = 2,
  parameter int ADDR_W    = 13,
  parameter int RFSH_W    = 12,
  parameter int CNT_W     = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        cke,
  input  logic                        cs_n,
  input  logic                        ras_n,
  input  logic                        cas_n,
  input  logic                        we_n,
  input  logic [BA_W-1:0]             ba,
  input  logic [ADDR_W-1:0]           addr,
  input  logic [2:0]                  cfg_cas,
  input  logic [3:0]                  cfg_trcd,
  input  logic [RFSH_W-1:0]           cfg_rfsh_max,
  input  logic                        rd_valid,
  input  logic                        err_clear,
  output logic                        cmd_valid,
  output logic [2:0]                  cmd_code,
  output logic [NUM_BANKS-1:0]        bank_open,
  output logic [CNT_W-1:0]            refresh_count,
  output logic                        rd_valid_exp,
  output logic [6:0]                  err_flags,
  // Debug view of the stored row per bank, bank b at [b*ADDR_W +: ADDR_W].
  output logic [NUM_BANKS*ADDR_W-1:0] bank_row
);

  typedef enum logic [2:0] {
    CMD_NOP = 3'd0,
    CMD_ACT = 3'd1,
    CMD_RD  = 3'd2,
    CMD_WR  = 3'd3,
    CMD_PRE = 3'd4,
    CMD_REF = 3'd5,
    CMD_MRS = 3'd6,
    CMD_BST = 3'd7
  } cmd_e;

  cmd_e                 cmd_d, cmd_q;
  logic [NUM_BANKS-1:0] open_d, open_q;
  logic [ADDR_W-1:0]    row_d [NUM_BANKS];
  logic [ADDR_W-1:0]    row_q [NUM_BANKS];
  logic [3:0]           since_d [NUM_BANKS];
  logic [3:0]           since_q [NUM_BANKS];
  logic [RFSH_W-1:0]    rfsh_cnt_d, rfsh_cnt_q;
  logic                 armed_d, armed_q;
  logic [CNT_W-1:0]     ref_count_d, ref_count_q;
  logic [7:0]           pipe_d, pipe_q;
  logic                 rd_exp_d, rd_exp_q;
  logic [6:0]           err_set, err_d, err_q;

  logic is_act, is_rd, is_wr, is_pre, is_ref, is_mrs;
  logic sel_open, trcd_bad;

  // Decode the sampled bus into a command code.
  always_comb begin
    cmd_d = CMD_NOP;
    if (cke && !cs_n) begin
      case ({ras_n, cas_n, we_n})
        3'b011:  cmd_d = CMD_ACT;
        3'b101:  cmd_d = CMD_RD;
        3'b100:  cmd_d = CMD_WR;
        3'b010:  cmd_d = CMD_PRE;
        3'b001:  cmd_d = CMD_REF;
        3'b000:  cmd_d = CMD_MRS;
        3'b110:  cmd_d = CMD_BST;
        default: cmd_d = CMD_NOP;
      endcase
    end
  end

  assign is_act = (cmd_d == CMD_ACT);
  assign is_rd  = (cmd_d == CMD_RD);
  assign is_wr  = (cmd_d == CMD_WR);
  assign is_pre = (cmd_d == CMD_PRE);
  assign is_ref = (cmd_d == CMD_REF);
  assign is_mrs = (cmd_d == CMD_MRS);

  // Error checks look at bank state from before this cycle's update.
  always_comb begin
    sel_open   = open_q[ba];
    trcd_bad   = ({1'b0, since_q[ba]} + 5'd1) < {1'b0, cfg_trcd};
    err_set    = '0;
    err_set[0] = (is_rd || is_wr) && !sel_open;
    err_set[1] = is_act && sel_open;
    err_set[2] = (is_ref || is_mrs) && (|open_q);
    err_set[3] = (is_rd || is_wr) && trcd_bad;
    err_set[4] = armed_q && (rfsh_cnt_q > cfg_rfsh_max);
    err_set[5] = (rd_valid != rd_exp_q);
    err_set[6] = is_rd && (cfg_cas == 3'd0);
    // A new violation wins over a simultaneous clear.
    err_d      = (err_q & ~{7{err_clear}}) | err_set;
  end

  // Per-bank open flags, stored rows and ACT-age counters.
  always_comb begin
    open_d = open_q;
    for (int b = 0; b < NUM_BANKS; b++) begin
      row_d[b]   = row_q[b];
      since_d[b] = (since_q[b] == 4'hF) ? since_q[b] : since_q[b] + 4'd1;
      if (is_act && (ba == BA_W'(b))) begin
        since_d[b] = '0;
        open_d[b]  = 1'b1;
        row_d[b]   = addr;
      end
    end
    if (is_pre) begin
      if (addr[10]) open_d = '0;
      else          open_d[ba] = 1'b0;
    end
  end

  // Refresh interval, refresh count and read-valid prediction.
  always_comb begin
    rfsh_cnt_d  = is_ref ? '0 :
                  ((&rfsh_cnt_q) ? rfsh_cnt_q : rfsh_cnt_q + RFSH_W'(1));
    armed_d     = armed_q | is_ref;
    ref_count_d = is_ref ? ref_count_q + CNT_W'(1) : ref_count_q;
    // A bit loaded at index cas reaches the output register cas+1 edges later.
    pipe_d      = {1'b0, pipe_q[7:1]};
    if (is_rd) pipe_d[cfg_cas] = 1'b1;
    rd_exp_d    = pipe_q[0];
  end

  // State registers; reset discards every in-flight item.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmd_q       <= CMD_NOP;
      open_q      <= '0;
      rfsh_cnt_q  <= '0;
      armed_q     <= 1'b0;
      ref_count_q <= '0;
      pipe_q      <= '0;
      rd_exp_q    <= 1'b0;
      err_q       <= '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
        row_q[b]   <= '0;
        since_q[b] <= '0;
      end
    end else begin
      cmd_q       <= cmd_d;
      open_q      <= open_d;
      rfsh_cnt_q  <= rfsh_cnt_d;
      armed_q     <= armed_d;
      ref_count_q <= ref_count_d;
      pipe_q      <= pipe_d;
      rd_exp_q    <= rd_exp_d;
      err_q       <= err_d;
      for (int b = 0; b < NUM_BANKS; b++) begin
        row_q[b]   <= row_d[b];
        since_q[b] <= since_d[b];
      end
    end
  end

  // Flatten stored rows for the debug output.
  always_comb begin
    bank_row = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      bank_row[b*ADDR_W +: ADDR_W] = row_q[b];
    end
  end

  assign cmd_code      = cmd_q;
  assign cmd_valid     = (cmd_q != CMD_NOP);
  assign bank_open     = open_q;
  assign refresh_count = ref_count_q;
  assign rd_valid_exp  = rd_exp_q;
  assign err_flags     = err_q;

endmodule

// File: doc/sdram_cmd_monitor.md
Name: sdram_cmd_monitor

Overview:
- Parametrised passive monitor for the SDRAM controller command bus. Instantiated alongside the core's whitebox probes and driven only by those probe signals; it never drives the DUT.
- Decodes each sampled command and tracks per-bank open/row state. Counts refreshes and checks the refresh interval.
- Predicts the read-data-valid timing from the CAS latency, and records protocol violations as sticky error flags for the scoreboard.
- Generalised in bank count, address width and refresh-timer width.

Parameters:
- NUM_BANKS, 4, number of SDRAM banks tracked; must be a power of 2.
- BA_W, 2, bank address width; equals log2(NUM_BANKS).
- ADDR_W, 13, SDRAM address bus width. Also the width of the stored row.
- RFSH_W, 12, width of the refresh-interval counter and of cfg_rfsh_max.
- CNT_W, 16, width of refresh_count.

Ports:
- clk  in  1  monitor clock; same clock as the SDRAM command bus.
- reset  in  1  asynchronous, active-high reset.
- cke  in  1  SDRAM clock enable.
- cs_n  in  1  chip select, active low.
- ras_n  in  1  row address strobe, active low.
- cas_n  in  1  column address strobe, active low.
- we_n  in  1  write enable, active low.
- ba  in  BA_W  bank address.
- addr  in  ADDR_W  SDRAM address; addr[10] is the precharge-all bit.
- cfg_cas  in  3  CAS latency, legal range 1..7.
- cfg_trcd  in  4  minimum number of cycles from ACT to RD/WR on the same bank.
- cfg_rfsh_max  in  RFSH_W  maximum allowed cycles between REF commands.
- rd_valid  in  1  observed controller read-valid.
- err_clear  in  1  single-cycle pulse that clears all error flags.
- cmd_valid  out  1  a non-NOP command was decoded in the previous cycle.
- cmd_code  out  3  decoded command: 0 NOP, 1 ACT, 2 RD, 3 WR, 4 PRE, 5 REF, 6 MRS, 7 BST.
- bank_open  out  NUM_BANKS  per-bank open-row flags.
- refresh_count  out  CNT_W  number of REF commands seen; wraps.
- rd_valid_exp  out  1  predicted rd_valid.
- err_flags  out  7  sticky error flags, bits assigned under Behaviour.

Behaviour:
- Reset: asynchronous, active-high, applies immediately. All outputs go to 0, all bank state is cleared, all counters are cleared and the rd_valid_exp pipeline is flushed. Reset asserted mid-sequence discards all in-flight state.
- Command decode on each rising clk edge:
  - cke=0 or cs_n=1 decodes as NOP.
  - Otherwise {ras_n,cas_n,we_n}: 011 ACT, 101 RD, 100 WR, 010 PRE, 001 REF, 000 MRS, 110 BST, 111 NOP.
  - cmd_code and cmd_valid are registered, so they appear one cycle after the bus sample.
- Per-bank state (for each bank b):
  - open[b] and row[b] (ADDR_W bits).
  - since_act[b]: a 4-bit counter, reset to 0 on ACT to bank b, incrementing each cycle and saturating at 15.
- Bank state updates, effective on the next cycle:
  - ACT sets open[ba] and stores row[ba]=addr.
  - PRE with addr[10]=1 clears all bank open flags; PRE with addr[10]=0 clears open[ba] only.
  - RD, WR, REF, MRS and BST do not change open[].
- Errors: a flag is set in the cycle after the triggering command.
  - err_flags[0]: RD or WR to a closed bank.
  - err_flags[1]: ACT to an already-open bank.
  - err_flags[2]: REF or MRS while any bank is open.
  - err_flags[3]: tRCD violation, i.e. RD or WR with since_act[ba] + 1 < cfg_trcd.
  - err_flags[4]: refresh timeout, i.e. the refresh-interval counter exceeds cfg_rfsh_max.
  - err_flags[5]: rd_valid differs from rd_valid_exp in the same cycle.
  - err_flags[6]: an illegal cfg_cas value of 0 sampled while an RD is decoded.
  - All flags are sticky until err_clear. If a set condition and err_clear occur in the same cycle, the set wins.
- Refresh-interval counter:
  - RFSH_W bits, counts every cycle.
  - Reloads to 0 on REF.
  - Saturates at all-ones, so no wrap-around is possible.
  - The timeout check begins only after the first REF following reset; before that, err_flags[4] is masked.
- refresh_count increments by 1 on each REF and wraps modulo 2^CNT_W.
- rd_valid_exp:
  - A shift register, 8 deep.
  - An RD decoded at cycle t asserts rd_valid_exp at cycle t + cfg_cas + 1, where the +1 is the monitor's own registration.
  - cfg_cas is sampled at the time of the RD. Back-to-back RDs produce back-to-back expected pulses.
- Simultaneous events:
  - Only one command per cycle exists on the bus.
  - The error check uses the bank state from before the update. Example: ACT to an open bank flags err_flags[1] and still reloads row[ba].

Test Plan:
- Reset then idle 10 cycles -> all outputs 0; err_flags=0 (refresh check masked).
- ACT bank1 row 0x0155, 3 NOPs, RD bank1, cfg_trcd=3, cfg_cas=3 -> bank_open=4'b0010; no error; rd_valid_exp high exactly 4 cycles after the RD sample.
- ACT bank2 then immediate RD bank2, cfg_trcd=3 -> err_flags[3]=1. Then err_clear pulse -> err_flags=0.
- ACT bank0, then REF -> err_flags[2]=1; PRE with addr[10]=1 -> bank_open=0; second REF -> refresh_count=2, no new error.
- cfg_rfsh_max=100: REF, then 101 cycles with no REF -> err_flags[4] set on the cycle the counter exceeds 100; further REFs do not clear the flag.
- RD with cfg_cas=2 while the driven rd_valid is delayed one cycle late -> err_flags[5]=1. Assert reset mid-pipeline -> rd_valid_exp=0 immediately and err_flags=0.
